// File: rtl/tarb_pkg.sv
// Shared types and sizing for the two-channel tuple/packet arbiter.
package tarb_pkg;

    localparam int N_CH        = 2;
    localparam int DATA_W_DEF  = 256;
    localparam int KEEP_W_DEF  = 32;
    localparam int TUPLE_W_DEF = 128;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TUPLE  = 3'd1,
        ST_STREAM = 3'd2
    } state_t;

    // Low bit of channel ch inside a packed per-channel bus of element width w.
    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/tuser_out_arb_if.sv
// Upstream channel bundle, downstream tuser_out_fsm side and status of the arbiter.
interface tuser_out_arb_if
    import tarb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEEP_W  = KEEP_W_DEF,
    parameter int TUPLE_W = TUPLE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) ();

    logic [N_CH-1:0]         avalid;
    logic [N_CH-1:0]         aready;
    logic [N_CH*DATA_W-1:0]  adata;
    logic [N_CH*KEEP_W-1:0]  akeep;
    logic [N_CH-1:0]         atlast;
    logic [N_CH-1:0]         tvalid;
    logic [N_CH*TUPLE_W-1:0] tdata;

    logic                    bvalid;
    logic                    bready;
    logic [DATA_W-1:0]       bdata;
    logic [KEEP_W-1:0]       bkeep;
    logic                    btlast;
    logic                    btvalid;
    logic [TUPLE_W-1:0]      btdata;

    logic [N_CH*CNT_W-1:0]   pkt_cnt;
    logic [N_CH-1:0]         tup_ovf;
    logic [2:0]              dbg_state;

    // Arbiter view.
    modport slave (
        input  avalid, adata, akeep, atlast, tvalid, tdata, bready,
        output aready, bvalid, bdata, bkeep, btlast, btvalid, btdata,
        output pkt_cnt, tup_ovf, dbg_state
    );

    // Environment view: channel sources plus the downstream consumer.
    modport master (
        output avalid, adata, akeep, atlast, tvalid, tdata, bready,
        input  aready, bvalid, bdata, bkeep, btlast, btvalid, btdata,
        input  pkt_cnt, tup_ovf, dbg_state
    );

endinterface

// File: rtl/tarb_tuple_slot.sv
// One-deep tuple holding register for a single channel.
// A strobe that lands on the same cycle the channel's packet finishes is
// kept, since the slot frees up on that very edge.
module tarb_tuple_slot #(
    parameter int TUPLE_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               strobe,
    input  logic [TUPLE_W-1:0] data_in,
    input  logic               clr,
    output logic               held,
    output logic [TUPLE_W-1:0] tuple,
    output logic               ovf
);

    logic take;

    assign take = strobe && (!held || clr);

    // Capture on a free (or freeing) slot, release on packet end, flag drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held  <= 1'b0;
            tuple <= '0;
            ovf   <= 1'b0;
        end else begin
            if (take) begin
                tuple <= data_in;
                held  <= 1'b1;
            end else if (clr) begin
                held  <= 1'b0;
            end
            if (strobe && held && !clr) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tuser_out_arb.sv
// Packet-granular round-robin arbiter feeding one tuser_out_fsm from two
// SDNet output channels. A channel competes only once its tuple is held;
// the grant then stays put until that channel's tlast beat is accepted.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | pick the next channel with a held tuple (round robin)
//   ST_TUPLE  | one-cycle tuple pulse to the downstream FSM
//   ST_STREAM | granted channel's beats pass straight through
module tuser_out_arb
    import tarb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEEP_W  = KEEP_W_DEF,
    parameter int TUPLE_W = TUPLE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic           tarb_aclk,
    input  logic           tarb_arst,
    tuser_out_arb_if.slave bus
);

    state_t             state_q;
    state_t             state_nxt;
    logic               g_q;
    logic               g_nxt;
    logic               last_g_q;
    logic               done;
    logic               grant_evt;
    logic [N_CH-1:0]    held;
    logic [N_CH-1:0]    ovf;
    logic [N_CH-1:0]    clr;
    logic [TUPLE_W-1:0] slot [N_CH];
    logic               btvalid_q;
    logic [TUPLE_W-1:0] btdata_q;
    logic [CNT_W-1:0]   pkt_cnt_q [N_CH];

    assign done      = (state_q == ST_STREAM) && bus.avalid[g_q] && bus.bready && bus.atlast[g_q];
    assign grant_evt = (state_q == ST_IDLE) && (state_nxt == ST_TUPLE);

    for (genvar n = 0; n < N_CH; n++) begin : g_slot
        assign clr[n] = done && (g_q == 1'(n));

        tarb_tuple_slot #(
            .TUPLE_W (TUPLE_W)
        ) u_slot (
            .clk     (tarb_aclk),
            .rst     (tarb_arst),
            .strobe  (bus.tvalid[n]),
            .data_in (bus.tdata[ch_lsb(n, TUPLE_W) +: TUPLE_W]),
            .clr     (clr[n]),
            .held    (held[n]),
            .tuple   (slot[n]),
            .ovf     (ovf[n])
        );
    end

    // Next state and grant choice; ties go to the channel not served last.
    always_comb begin
        state_nxt = state_q;
        g_nxt     = g_q;
        case (state_q)
            ST_IDLE: begin
                if (held == 2'b11) begin
                    g_nxt     = ~last_g_q;
                    state_nxt = ST_TUPLE;
                end else if (held[0]) begin
                    g_nxt     = 1'b0;
                    state_nxt = ST_TUPLE;
                end else if (held[1]) begin
                    g_nxt     = 1'b1;
                    state_nxt = ST_TUPLE;
                end
            end
            ST_TUPLE:  state_nxt = ST_STREAM;
            ST_STREAM: if (done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State, grant, tuple pulse and per-channel packet counters.
    always_ff @(posedge tarb_aclk or posedge tarb_arst) begin
        if (tarb_arst) begin
            state_q   <= ST_IDLE;
            g_q       <= 1'b0;
            last_g_q  <= 1'b1;
            btvalid_q <= 1'b0;
            btdata_q  <= '0;
            for (int n = 0; n < N_CH; n++) begin
                pkt_cnt_q[n] <= '0;
            end
        end else begin
            state_q   <= state_nxt;
            g_q       <= g_nxt;
            btvalid_q <= grant_evt;
            btdata_q  <= grant_evt ? slot[g_nxt] : '0;
            if (done) begin
                last_g_q       <= g_q;
                pkt_cnt_q[g_q] <= pkt_cnt_q[g_q] + CNT_W'(1);
            end
        end
    end

    // Combinational pass-through of the granted channel while streaming.
    always_comb begin
        bus.aready = '0;
        bus.bvalid = 1'b0;
        bus.bdata  = '0;
        bus.bkeep  = '0;
        bus.btlast = 1'b0;
        if (state_q == ST_STREAM) begin
            bus.aready[g_q] = bus.bready;
            bus.bvalid      = bus.avalid[g_q];
            bus.bdata       = bus.adata[ch_lsb(int'(g_q), DATA_W) +: DATA_W];
            bus.bkeep       = bus.akeep[ch_lsb(int'(g_q), KEEP_W) +: KEEP_W];
            bus.btlast      = bus.atlast[g_q];
        end
    end

    assign bus.btvalid   = btvalid_q;
    assign bus.btdata    = btdata_q;
    assign bus.pkt_cnt   = {pkt_cnt_q[1], pkt_cnt_q[0]};
    assign bus.tup_ovf   = ovf;
    assign bus.dbg_state = state_q;

endmodule
